// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter that shares one registered output lane among four
//   requesters (a, b, c, d), each with its own valid/ready handshake.
//   The winning operand is captured in a one-entry output register that
//   drains to the downstream consumer of o_y.
//
// Ports
//   i_clk      clock, all state on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_a..i_d   requester 0..3 data (P_WIDTH)
//   i_valid    per-requester valid, bit n = requester n
//   o_ready    per-requester ready, one-hot or zero
//   o_y        registered selected data
//   o_valid    o_y holds a valid beat
//   i_ready    downstream accepts o_y this cycle
//   o_gnt_id   index of the requester whose data sits in o_y
//
// Parameters
//   P_WIDTH    data width
//   P_BURST    max consecutive beats per requester (1..15), burst build only
//
// Build option
//   RR_ARB_BURST_EN  when defined, a requester keeps first place in line for
//                    up to P_BURST consecutive beats before the pointer moves.
//
// Output register state
//   state    | meaning
//   ST_EMPTY | o_y holds no beat, a new beat may always be loaded
//   ST_FULL  | o_y holds a beat, reload only when downstream pops it

module rr_mux_arbiter #(
   parameter int P_WIDTH = 8,
   parameter int P_BURST = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [P_WIDTH-1:0] i_a,
   input  logic [P_WIDTH-1:0] i_b,
   input  logic [P_WIDTH-1:0] i_c,
   input  logic [P_WIDTH-1:0] i_d,
   input  logic [3:0]         i_valid,
   output logic [3:0]         o_ready,
   output logic [P_WIDTH-1:0] o_y,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [1:0]         o_gnt_id
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               state_nxt;
   logic [1:0]           r_ptr;
   logic [1:0]           ptr_nxt;
   logic                 load_en;
   logic                 win_found;
   logic [1:0]           win_id;
   logic [P_WIDTH-1:0]   win_data;
   logic                 xfer;

   assign o_valid = (r_state == ST_FULL);
   assign load_en = (r_state == ST_EMPTY) | i_ready;

   // Priority search starting at r_ptr; the 2-bit index wraps naturally.
   always_comb begin
      logic [1:0] idx;
      win_found = 1'b0;
      win_id    = r_ptr;
      idx       = r_ptr;
      for (int k = 0; k < 4; k++) begin
         idx = r_ptr + 2'(k);
         if (!win_found && i_valid[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   always_comb begin
      win_data = i_a;
      case (win_id)
         2'd0:    win_data = i_a;
         2'd1:    win_data = i_b;
         2'd2:    win_data = i_c;
         default: win_data = i_d;
      endcase
   end

   // Ready is gated by reset itself so no handshake can complete while
   // reset is asserted, including the cycle in which it is asserted.
   always_comb begin
      o_ready = 4'b0000;
      if (i_rst_n && load_en && win_found) begin
         o_ready[win_id] = 1'b1;
      end
   end

   assign xfer = |(i_valid & o_ready);

   always_comb begin
      state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (xfer) state_nxt = ST_FULL;
         ST_FULL: begin
            if (xfer)         state_nxt = ST_FULL;
            else if (i_ready) state_nxt = ST_EMPTY;
         end
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_y      <= '0;
         o_gnt_id <= 2'd0;
      end else if (xfer) begin
         o_y      <= win_data;
         o_gnt_id <= win_id;
      end
   end

`ifdef RR_ARB_BURST_EN
   logic [3:0] r_burst;
   logic [3:0] burst_nxt;
   logic [3:0] burst_cur;

   // While a burst is running the pointer sits on the holder, so a winner
   // equal to r_ptr continues the burst; any other winner starts fresh.
   always_comb begin
      ptr_nxt   = r_ptr;
      burst_nxt = r_burst;
      burst_cur = (win_id == r_ptr) ? r_burst : 4'd0;
      if (xfer) begin
         if (burst_cur < 4'(P_BURST - 1)) begin
            ptr_nxt   = win_id;
            burst_nxt = burst_cur + 4'd1;
         end else begin
            ptr_nxt   = win_id + 2'd1;
            burst_nxt = 4'd0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_burst <= 4'd0;
      end else begin
         r_burst <= burst_nxt;
      end
   end
`else
   // Burst length has no effect in the pure round-robin build.
   if (P_BURST < 1) begin : g_burst_unused
   end

   always_comb begin
      ptr_nxt = r_ptr;
      if (xfer) begin
         ptr_nxt = win_id + 2'd1;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= 2'd0;
      end else begin
         r_ptr <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

   localparam int W  = 8;
   localparam int PB = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] a, b, c, d;
   logic [3:0]   vld;
   logic [3:0]   rdy;
   logic [W-1:0] y;
   logic         ov;
   logic         irdy;
   logic [1:0]   gid;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] data;
   } beat_t;

   beat_t sb[$];

   logic [1:0] m_ptr;
   logic       m_full;
   int         m_run;
   logic [1:0] m_last;

   rr_mux_arbiter #(.P_WIDTH(W), .P_BURST(PB)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_a      (a),
      .i_b      (b),
      .i_c      (c),
      .i_d      (d),
      .i_valid  (vld),
      .o_ready  (rdy),
      .o_y      (y),
      .o_valid  (ov),
      .i_ready  (irdy),
      .o_gnt_id (gid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 2'd0;
      m_full = 1'b0;
      m_run  = 0;
      m_last = 2'd0;
      sb.delete();
   endtask

   function automatic logic [3:0] m_ready();
      logic [1:0] idx;
      if (!rst_n) return 4'b0000;
      if (m_full && !irdy) return 4'b0000;
      for (int k = 0; k < 4; k++) begin
         idx = m_ptr + 2'(k);
         if (vld[idx]) return 4'b0001 << idx;
      end
      return 4'b0000;
   endfunction

   function automatic logic [W-1:0] data_of(input logic [1:0] n);
      case (n)
         2'd0:    return a;
         2'd1:    return b;
         2'd2:    return c;
         default: return d;
      endcase
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic cycle(input string tag);
      logic [3:0] er;
      logic [1:0] n;
      beat_t      e;
      #1;
      er = m_ready();
      chk({tag, ".ready"}, rdy, er);
      n = 2'd0;
      for (int k = 0; k < 4; k++) if (er[k]) n = 2'(k);
      @(posedge clk);
      if (er != 4'b0000) begin
         sb.push_back('{id: n, data: data_of(n)});
         m_full = 1'b1;
`ifdef RR_ARB_BURST_EN
         if (m_run > 0 && n == m_last) m_run++;
         else m_run = 1;
         m_last = n;
         if (m_run >= PB) begin
            m_ptr = n + 2'd1;
            m_run = 0;
         end else begin
            m_ptr = n;
         end
`else
         m_ptr = n + 2'd1;
`endif
      end else if (m_full && irdy) begin
         m_full = 1'b0;
      end
      @(negedge clk);
      chk({tag, ".valid"}, ov, m_full);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, ".y"}, y, e.data);
         chk({tag, ".gnt_id"}, gid, e.id);
      end
   endtask

   initial begin
      logic [W-1:0] rot_y [4];
      logic [W-1:0] exp_y;
      logic [1:0]   exp_id;
      rot_y[0] = 8'h11; rot_y[1] = 8'h22; rot_y[2] = 8'h33; rot_y[3] = 8'h44;

      // Reset with everyone requesting
      a = '0; b = '0; c = '0; d = '0;
      vld = 4'hF; irdy = 1'b1; rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst.ready", rdy, 4'b0000);
      chk("rst.valid", ov, 1'b0);
      chk("rst.y", y, 8'h00);
      chk("rst.gnt_id", gid, 2'd0);
      rst_n = 1'b1;
      #1;
      chk("rst.first_grant", rdy, 4'b0001);

      // Rotation with all four requesting
      a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
      for (int k = 0; k < 8; k++) begin
         cycle("rot");
`ifdef RR_ARB_BURST_EN
         exp_id = (k < 4) ? 2'd0 : 2'd1;
`else
         exp_id = 2'(k % 4);
`endif
         exp_y = rot_y[exp_id];
         chk("rot.seq_y", y, exp_y);
         chk("rot.seq_id", gid, exp_id);
      end

      // Drain, then load b and stall the downstream
      vld = 4'b0000; irdy = 1'b1;
      cycle("drain0");
      b = 8'h5A; vld = 4'b0010; irdy = 1'b0;
      cycle("fill_b");
      chk("fill_b.y", y, 8'h5A);
      vld = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         cycle("bp");
         chk("bp.ready", rdy, 4'b0000);
         chk("bp.y_hold", y, 8'h5A);
         chk("bp.valid_hold", ov, 1'b1);
      end
      irdy = 1'b1;
      #1;
      chk("bp.release_grant", rdy, 4'b1000);
      cycle("bp_release");
      chk("bp.release_y", y, 8'h44);

      // Single beat from c, then a bubble
      c = 8'h7E; vld = 4'b0100;
      cycle("single_c");
      chk("single_c.valid", ov, 1'b1);
      chk("single_c.y", y, 8'h7E);
      vld = 4'b0000;
      cycle("bubble");
      chk("bubble.valid", ov, 1'b0);
      chk("bubble.y_hold", y, 8'h7E);

      // Reset while a beat is held
      vld = 4'hF;
      cycle("pre_rst");
      cycle("pre_rst");
      chk("pre_rst.valid", ov, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst.valid", ov, 1'b0);
      chk("mid_rst.ready", rdy, 4'b0000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst.restart_grant", rdy, 4'b0001);
      cycle("post_rst");
      chk("post_rst.gnt_id", gid, 2'd0);

      // Two requesters competing from a fresh start
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      a = 8'hA1; b = 8'hB2; vld = 4'b0011; irdy = 1'b1;
      for (int k = 0; k < 9; k++) begin
         cycle("pair");
`ifdef RR_ARB_BURST_EN
         exp_id = 2'((k / PB) % 2);
`else
         exp_id = 2'(k % 2);
`endif
         chk("pair.seq_id", gid, exp_id);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
